sl_receiver: RTL and testbench
==============================

# sl_receiver

Receiver for the two-wire SL serial link, sitting between the external sl0/sl1 lines and the internal bus bridge. It decodes return-to-idle pulses into data bits, frames messages on the stop condition, and checks odd parity. It presents the received word right-aligned on a 32-bit output with a valid flag.

## Interface
- Parameters: none. Word length is selected at run time by `mode`.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sl0`  in  1  line 0; idle high; a low pulse encodes bit 0. Asynchronous to `clk`.
- `sl1`  in  1  line 1; idle high; a low pulse encodes bit 1. Asynchronous to `clk`.
- `mode`  in  2  data length: 00 = 8, 01 = 16, 10 = 24, 11 = 32 data bits. Each message is that many data bits plus 1 parity bit.
- `data`  out  32  last good word, right-aligned, upper bits zero.
- `valid`  out  1  `data` holds a good, parity-checked word.
- `ready`  out  1  receiver is idle; no message is in progress.

## Operation
- **Input synchronization.** `sl0` and `sl1` each pass through a 2-FF synchronizer. All decoding uses the synchronized values s0/s1.
- **Bit 0.** s0 falls while s1 is high, then s0 rises while s1 stayed high throughout. The bit is accepted on the rising edge of s0.
- **Bit 1.** The same as bit 0 with the roles of s0 and s1 swapped.
- **Stop condition.** s0 and s1 are both low in the same cycle. The two falls may occur in any order and with any skew.
- **State machine.**
  - IDLE: `ready` = 1. The first accepted bit latches `mode`, clears the shift register, sets the bit count to 1 and moves to RECV. A stop seen in IDLE moves to STOP_WAIT with no effect on outputs.
  - RECV: each accepted bit shifts in MSB-first (first bit received ends up as MSB of the data field) and increments the count. A bit beyond data length + 1 moves to ERR. A stop moves to CHECK.
  - CHECK (1 cycle): the message is good if the count equals length + 1 and the total number of ones over data and parity bits is odd.
    - Good: `data` <= data bits zero-extended, `valid` <= 1.
    - Bad: `data` and `valid` are unchanged.
    - Then go to STOP_WAIT.
  - ERR: ignore bits until a stop, then go to STOP_WAIT. Outputs are unchanged.
  - STOP_WAIT: wait until s0 and s1 are both high, then go to IDLE.
- **Output ownership.** `valid` stays high until the first accepted bit of the next message, which clears it in the same cycle RECV is entered. `data` holds its value until the next good message.
- **Mode latching.** `mode` is sampled only at message start. A change of `mode` mid-message has no effect on the current message.
- **Reset values.** `data` = 0, `valid` = 0, `ready` = 1, state = IDLE, shift register = 0, count = 0.
- **Reset mid-message.** Reset returns the block to IDLE. The partial message is discarded. If the lines are not idle when reset is released, the decoder does not enter STOP_WAIT; the rules below apply.
- **Rules for non-idle lines at reset release:**
  - A line already low at reset release gives no bit, because no falling edge was seen.
  - Both lines low at reset release counts as a stop.

## Timing
- Each low pulse and each idle gap is at least 3 `clk` periods wide.
- Synchronizer latency is 2 cycles.
- A bit is counted 1 cycle after the synchronized rising edge.
- CHECK occurs 1 cycle after the stop is detected.
- `valid` and `data` update 1 cycle after CHECK. That is at most 4 `clk` cycles after both raw lines are low.
- `ready` falls the cycle RECV is entered and rises the cycle IDLE is re-entered.
- If both lines fall in the same cycle, that is a stop and no bit is counted.

## Structure
- Shared package `sl_pkg`, containing:
  - the state enum (IDLE, RECV, CHECK, ERR, STOP_WAIT);
  - the `mode`-to-length constants 8, 16, 24 and 32;
  - `SL_MAX_BITS` = 33.
- One sub-module `sl_line_sync`: a 2-FF synchronizer plus a registered previous value, providing fall and rise strobes per line. It is instantiated twice.
- The shift register is 33 bits and the count is 6 bits.

## Test plan
- **Good 16-bit message.** Reset, `mode` = 01, then the pulse sequence 1,1,0,0,1,0,1,1,0,1,1,0,0,1,0,1 + parity 0, then stop (sl0 low, sl1 low 2 units later). Required: `data` = 0x0000CB65, `valid` = 1, `ready` returns to 1.
- **Parity error.** The same message with parity bit 1. Required: `valid` stays 0 and `data` stays 0.
- **Short and long messages.** 16 bits total with `mode` = 01 → rejected. 18 bits → ERR state, rejected, and the next good message is accepted.
- **8-bit message.** `mode` = 00, data 0xA5, parity 1. Required: `data` = 0x000000A5. The next message's first bit clears `valid`.
- **32-bit message.** `mode` = 11, data 0xDEADBEEF, parity 1. Required: `data` = 0xDEADBEEF.
- **Reset mid-message.** Send 5 bits, assert reset, then send a good message. Required: `data` and `valid` are 0 after reset, and the good message is received correctly.

Source files
------------

// File: rtl/sl_pkg.sv
// Shared types and constants for the SL serial link receiver.
package sl_pkg;

  localparam int unsigned SL_MAX_BITS = 33;
  localparam int unsigned SL_CNT_W    = 6;
  localparam int unsigned SL_DATA_W   = 32;
  localparam int unsigned SL_MODE_W   = 2;

  localparam logic [SL_CNT_W-1:0] SL_LEN_8  = 6'd8;
  localparam logic [SL_CNT_W-1:0] SL_LEN_16 = 6'd16;
  localparam logic [SL_CNT_W-1:0] SL_LEN_24 = 6'd24;
  localparam logic [SL_CNT_W-1:0] SL_LEN_32 = 6'd32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RECV      = 3'd1,
    CHECK     = 3'd2,
    ERR       = 3'd3,
    STOP_WAIT = 3'd4
  } sl_state_e;

  // Number of data bits selected by the run-time mode input.
  function automatic logic [SL_CNT_W-1:0] sl_len(input logic [SL_MODE_W-1:0] mode);
    logic [SL_CNT_W-1:0] len;
    case (mode)
      2'b00:   len = SL_LEN_8;
      2'b01:   len = SL_LEN_16;
      2'b10:   len = SL_LEN_24;
      default: len = SL_LEN_32;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/sl_line_sync.sv
// Two-flop synchronizer for one SL line with edge strobes.
// The strobes and the low level are held off until the pipeline carries real
// samples, so a line already low at reset release produces no fall.
module sl_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic low_c,
  output logic fall_c,
  output logic rise_c
);

  logic       meta_q, meta_d;
  logic       sync_q, sync_d;
  logic       prev_q, prev_d;
  logic [1:0] fill_q, fill_d;
  logic       live_c;

  // Next-state for the sync pipeline and the fill counter.
  always_comb begin
    meta_d = line;
    sync_d = meta_q;
    prev_d = sync_q;
    fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
  end

  // Pipeline registers; reset to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      fill_q <= 2'd0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      fill_q <= fill_d;
    end
  end

  assign live_c = (fill_q == 2'd3);
  assign low_c  = live_c & ~sync_q;
  assign fall_c = live_c & prev_q & ~sync_q;
  assign rise_c = live_c & ~prev_q & sync_q;

endmodule

// File: rtl/sl_receiver.sv
// SL two-wire receiver: decodes return-to-idle pulses, frames on stop,
// checks odd parity and presents the last good word.
module sl_receiver
  import sl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sl0,
  input  logic                 sl1,
  input  logic [SL_MODE_W-1:0] mode,
  output logic [SL_DATA_W-1:0] data,
  output logic                 valid,
  output logic                 ready
);

  logic low0_c, fall0_c, rise0_c;
  logic low1_c, fall1_c, rise1_c;

  sl_line_sync u_sync0 (
    .clk    (clk),
    .rst_n  (reset),
    .line   (sl0),
    .low_c  (low0_c),
    .fall_c (fall0_c),
    .rise_c (rise0_c)
  );

  sl_line_sync u_sync1 (
    .clk    (clk),
    .rst_n  (reset),
    .line   (sl1),
    .low_c  (low1_c),
    .fall_c (fall1_c),
    .rise_c (rise1_c)
  );

  sl_state_e               state_q, state_d;
  logic [SL_MAX_BITS-1:0]  shreg_q, shreg_d;
  logic [SL_CNT_W-1:0]     cnt_q, cnt_d;
  logic [SL_MODE_W-1:0]    mode_q, mode_d;
  logic [SL_DATA_W-1:0]    data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    ready_q, ready_d;
  logic                    arm0_q, arm0_d;
  logic                    arm1_q, arm1_d;

  logic                    bit_vld_c;
  logic                    bit_val_c;
  logic                    stop_c;
  logic                    idle_c;
  logic [SL_CNT_W-1:0]     len_p1_c;

  // A pulse is armed by its fall and disarmed if the other line drops.
  always_comb begin
    arm0_d = arm0_q;
    arm1_d = arm1_q;
    if (low1_c)       arm0_d = 1'b0;
    else if (fall0_c) arm0_d = 1'b1;
    else if (rise0_c) arm0_d = 1'b0;
    if (low0_c)       arm1_d = 1'b0;
    else if (fall1_c) arm1_d = 1'b1;
    else if (rise1_c) arm1_d = 1'b0;
  end

  assign bit_vld_c = (rise0_c & arm0_q & ~low1_c) | (rise1_c & arm1_q & ~low0_c);
  assign bit_val_c = rise1_c;
  assign stop_c    = low0_c & low1_c;
  assign idle_c    = ~low0_c & ~low1_c;
  assign len_p1_c  = sl_len(mode_q) + 6'd1;

  // Message framing FSM: next state and register updates.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (bit_vld_c) begin
          state_d = RECV;
          mode_d  = mode;
          shreg_d = SL_MAX_BITS'(bit_val_c);
          cnt_d   = 6'd1;
          valid_d = 1'b0;
        end else if (stop_c) begin
          state_d = STOP_WAIT;
        end
      end
      RECV: begin
        if (stop_c) begin
          state_d = CHECK;
        end else if (bit_vld_c) begin
          if (cnt_q == len_p1_c) begin
            state_d = ERR;
          end else begin
            shreg_d = {shreg_q[SL_MAX_BITS-2:0], bit_val_c};
            cnt_d   = cnt_q + 6'd1;
          end
        end
      end
      CHECK: begin
        if ((cnt_q == len_p1_c) && (^shreg_q)) begin
          data_d  = shreg_q[SL_MAX_BITS-1:1];
          valid_d = 1'b1;
        end
        state_d = STOP_WAIT;
      end
      ERR: begin
        if (stop_c) state_d = STOP_WAIT;
      end
      STOP_WAIT: begin
        if (idle_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      arm0_q  <= 1'b0;
      arm1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      arm0_q  <= arm0_d;
      arm1_q  <= arm1_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_sl_receiver.sv
// Self-checking bench for sl_receiver: random pulse stimulus, word-level model,
// scoreboard popped by a monitor on each rising valid.
module tb_sl_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        sl0;
  logic        sl1;
  logic [1:0]  mode;
  logic [31:0] data;
  logic        valid;
  logic        ready;

  always #5 clk = ~clk;

  sl_receiver dut (
    .clk   (clk),
    .reset (reset),
    .sl0   (sl0),
    .sl1   (sl1),
    .mode  (mode),
    .data  (data),
    .valid (valid),
    .ready (ready)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] sb_q[$];
  bit          msg_q[$];
  logic [31:0] model_data  = 32'h0;
  logic        model_valid = 1'b0;
  logic        valid_prev  = 1'b0;
  logic [31:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every new word presented by the DUT must match the scoreboard head.
  always @(negedge clk) begin
    if (reset === 1'b1 && valid === 1'b1 && valid_prev === 1'b0) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got data 0x%08h, want no new word", data);
      end else begin
        mon_exp = sb_q.pop_front();
        check("sb_data", data, mon_exp);
      end
    end
    valid_prev = valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    if (b) sl1 = 1'b0;
    else   sl0 = 1'b0;
    tick($urandom_range(3, 5));
    sl0 = 1'b1;
    sl1 = 1'b1;
    tick($urandom_range(4, 6));
  endtask

  task automatic send_stop(input int skew);
    sl0 = 1'b0;
    tick(skew);
    sl1 = 1'b0;
    tick(3);
    if ($urandom_range(0, 1) == 1) begin
      sl0 = 1'b1;
      tick($urandom_range(0, 2));
      sl1 = 1'b1;
    end else begin
      sl1 = 1'b1;
      tick($urandom_range(0, 2));
      sl0 = 1'b0 | 1'b1;
    end
    tick(8);
  endtask

  // Bit list: len data bits MSB-first, odd-parity bit, then trimmed/padded to nbits.
  task automatic build_msg(input logic [31:0] w, input int len, input bit flip_par, input int nbits);
    int ones = 0;
    msg_q.delete();
    for (int i = 0; i < len; i++) begin
      msg_q.push_back(w[len-1-i]);
      ones += int'(w[len-1-i]);
    end
    msg_q.push_back(((ones % 2) == 0) ^ flip_par);
    while (msg_q.size() > nbits) void'(msg_q.pop_back());
    while (msg_q.size() < nbits) msg_q.push_back(1'($urandom_range(0, 1)));
  endtask

  // Send msg_q as one message; model decides from word-level rules.
  task automatic send_msg(input logic [1:0] m, input int skew, input bit chg_mode);
    int          len  = 8 * (int'(m) + 1);
    int          ones = 0;
    logic [31:0] word = 32'h0;
    bit          good;
    foreach (msg_q[i]) ones += int'(msg_q[i]);
    for (int i = 0; i < len && i < msg_q.size(); i++) word = {word[30:0], msg_q[i]};
    good = (msg_q.size() == len + 1) && ((ones % 2) == 1);
    mode = m;
    for (int i = 0; i < msg_q.size(); i++) begin
      send_bit(msg_q[i]);
      if (i == 0) begin
        model_valid = 1'b0;
        check("first_bit_clears_valid", 32'(valid), 32'(model_valid));
        check("busy_not_ready", 32'(ready), 32'h0);
        if (chg_mode) mode = ~m;
      end
    end
    if (good) begin
      sb_q.push_back(word);
      model_data  = word;
      model_valid = 1'b1;
    end
    send_stop(skew);
    check("ready_after_msg", 32'(ready), 32'h1);
    check("valid_after_msg", 32'(valid), 32'(model_valid));
    check("data_after_msg", data, model_data);
    check("sb_drained", 32'(sb_q.size()), 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    sl0   = 1'b1;
    sl1   = 1'b1;
    mode  = 2'b00;
    tick(3);
    check("reset_data", data, 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_ready", 32'(ready), 32'h1);
    reset = 1'b1;
    tick(4);

    // Parity error, then the same word with correct parity.
    build_msg(32'h0000CB65, 16, 1'b1, 17);
    send_msg(2'b01, 2, 1'b0);
    build_msg(32'h0000CB65, 16, 1'b0, 17);
    send_msg(2'b01, 2, 1'b0);
    check("good16_word", data, 32'h0000CB65);

    // Short and long frames are rejected; a good frame follows.
    build_msg(32'h00001234, 16, 1'b0, 16);
    send_msg(2'b01, 1, 1'b0);
    build_msg(32'h00005A5A, 16, 1'b0, 18);
    send_msg(2'b01, 0, 1'b0);
    build_msg(32'h00000F0F, 16, 1'b0, 17);
    send_msg(2'b01, 3, 1'b0);

    // 8-bit and 32-bit words.
    build_msg(32'h000000A5, 8, 1'b0, 9);
    send_msg(2'b00, 2, 1'b0);
    check("good8_word", data, 32'h000000A5);
    build_msg(32'hDEADBEEF, 32, 1'b0, 33);
    send_msg(2'b11, 1, 1'b1);
    check("good32_word", data, 32'hDEADBEEF);

    // Reset part-way through a message.
    mode = 2'b10;
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    reset = 1'b0;
    tick(2);
    model_data  = 32'h0;
    model_valid = 1'b0;
    check("midreset_data", data, 32'h0);
    check("midreset_valid", 32'(valid), 32'h0);
    check("midreset_ready", 32'(ready), 32'h1);
    reset = 1'b1;
    tick(4);
    build_msg(32'h00C0FFEE, 24, 1'b0, 25);
    send_msg(2'b10, 2, 1'b0);

    // One line low at reset release: its later rise gives no bit.
    reset = 1'b0;
    sl0   = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(5);
    sl0 = 1'b1;
    tick(6);
    check("lowline_no_bit", 32'(ready), 32'h1);
    model_data  = 32'h0;
    model_valid = 1'b0;
    build_msg(32'h0000003C, 8, 1'b0, 9);
    send_msg(2'b00, 1, 1'b0);

    // Both lines low at reset release act as a stop, then recover.
    reset = 1'b0;
    sl0   = 1'b0;
    sl1   = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(6);
    sl0 = 1'b1;
    sl1 = 1'b1;
    tick(6);
    check("bothlow_recover", 32'(ready), 32'h1);
    model_data  = 32'h0;
    model_valid = 1'b0;
    build_msg(32'h0000BEEF, 16, 1'b0, 17);
    send_msg(2'b01, 0, 1'b0);

    // Random messages: mostly good, some short/long/bad parity, mode wiggles.
    for (int n = 0; n < 16; n++) begin
      logic [1:0]  m;
      int          len;
      int          r;
      int          nb;
      m   = 2'($urandom_range(0, 3));
      len = 8 * (int'(m) + 1);
      r   = $urandom_range(0, 9);
      nb  = (r == 0) ? len : ((r == 1) ? len + 2 : len + 1);
      build_msg($urandom, len, (r == 2), nb);
      send_msg(m, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check("final_sb_empty", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
